// File: rtl/sequencer_if.sv
// sequencer_if: control/status bundle between the sequencer and the datapath
interface sequencer_if #(
  parameter int OP_W = 3
);
  logic [OP_W-1:0] op;
  logic z_flag;
  logic mem_ready;
  logic ACC_bus;
  logic load_ACC;
  logic PC_bus;
  logic load_PC;
  logic INC_PC;
  logic load_IR;
  logic Addr_bus;
  logic load_MAR;
  logic MDR_bus;
  logic load_MDR;
  logic CS;
  logic R_NW;
  logic ALU_ACC;
  logic ALU_add;
  logic ALU_sub;
  logic halted;

  modport master (
    input  op, z_flag, mem_ready,
    output ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus,
           load_MAR, MDR_bus, load_MDR, CS, R_NW, ALU_ACC, ALU_add, ALU_sub, halted
  );

  modport slave (
    output op, z_flag, mem_ready,
    input  ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus,
           load_MAR, MDR_bus, load_MDR, CS, R_NW, ALU_ACC, ALU_add, ALU_sub, halted
  );
endinterface

// File: rtl/sequencer.sv
// sequencer: fetch/decode/execute control FSM with memory-ready wait states and sticky illegal-opcode halt
module sequencer #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input logic clock,
  input logic reset,
  sequencer_if.master bus
);
  if (OP_W > WORD_W) begin : g_bad_width
    $error("opcode field wider than the bus word");
  end

  typedef enum logic [2:0] {FETCH_A, FETCH_D, DECODE, EXEC_RD, EXEC_WR, HALT} state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);

  state_t state, state_next;
  logic is_add, is_sub, is_rd, is_st, is_bne;

  assign is_add = bus.op == OP_ADD;
  assign is_sub = bus.op == OP_SUB;
  assign is_rd  = bus.op == OP_LOAD || is_add || is_sub;
  assign is_st  = bus.op == OP_STORE;
  assign is_bne = bus.op == OP_BNE;

  // state register; reset forces an immediate return to instruction fetch
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= FETCH_A;
    else       state <= state_next;

  // next-state and strobe decode; every strobe idles low, R_NW idles in read
  always_comb begin
    state_next   = state;
    bus.ACC_bus  = 1'b0;
    bus.load_ACC = 1'b0;
    bus.PC_bus   = 1'b0;
    bus.load_PC  = 1'b0;
    bus.INC_PC   = 1'b0;
    bus.load_IR  = 1'b0;
    bus.Addr_bus = 1'b0;
    bus.load_MAR = 1'b0;
    bus.MDR_bus  = 1'b0;
    bus.load_MDR = 1'b0;
    bus.CS       = 1'b0;
    bus.R_NW     = 1'b1;
    bus.ALU_ACC  = 1'b0;
    bus.ALU_add  = 1'b0;
    bus.ALU_sub  = 1'b0;
    bus.halted   = 1'b0;
    case (state)
      FETCH_A: begin
        bus.PC_bus   = 1'b1;
        bus.load_MAR = 1'b1;
        bus.INC_PC   = 1'b1;
        state_next   = FETCH_D;
      end
      FETCH_D: begin
        bus.CS      = 1'b1;
        bus.MDR_bus = bus.mem_ready;
        bus.load_IR = bus.mem_ready;
        state_next  = bus.mem_ready ? DECODE : FETCH_D;
      end
      DECODE: begin
        if (is_rd || is_st) begin
          bus.Addr_bus = 1'b1;
          bus.load_MAR = 1'b1;
          state_next   = is_st ? EXEC_WR : EXEC_RD;
        end else if (is_bne) begin
          bus.Addr_bus = !bus.z_flag;
          bus.load_PC  = !bus.z_flag;
          state_next   = FETCH_A;
        end else begin
          state_next   = HALT;
        end
      end
      EXEC_RD: begin
        bus.CS       = 1'b1;
        bus.MDR_bus  = bus.mem_ready;
        bus.load_ACC = bus.mem_ready;
        bus.ALU_ACC  = bus.mem_ready && (is_add || is_sub);
        bus.ALU_add  = bus.mem_ready && is_add;
        bus.ALU_sub  = bus.mem_ready && is_sub;
        state_next   = bus.mem_ready ? FETCH_A : EXEC_RD;
      end
      EXEC_WR: begin
        bus.CS       = 1'b1;
        bus.R_NW     = 1'b0;
        bus.ACC_bus  = 1'b1;
        bus.load_MDR = 1'b1;
        state_next   = bus.mem_ready ? FETCH_A : EXEC_WR;
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      default: state_next = FETCH_A;
    endcase
  end
endmodule

// File: doc/sequencer.md
# sequencer

Control-unit state machine for the basic 8-bit processor. It sequences fetch, decode and execute over the shared `sysbus`. It drives every load and bus-enable strobe for the PC, IR, ACC, ALU and the memory MAR/MDR pair (ROM and RAM share the memory strobes). A memory-ready handshake lets slow memories stretch access cycles, and an illegal opcode parks the machine in a sticky halt.

## Interface
- `WORD_W`, 8, system bus width.
- `OP_W`, 3, opcode width (IR[WORD_W-1 -: OP_W]).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op`  in  OP_W  opcode field of IR.
- `z_flag`  in  1  ACC == 0 flag from ALU.
- `mem_ready`  in  1  memory has completed the current access.
- `ACC_bus`, `load_ACC`  out  1 each  ACC drives `sysbus` / ACC captures.
- `PC_bus`, `load_PC`, `INC_PC`  out  1 each  PC drives bus / PC loads from bus / PC increments.
- `load_IR`, `Addr_bus`  out  1 each  IR captures / IR address field drives bus.
- `load_MAR`, `MDR_bus`, `load_MDR`  out  1 each  memory address and data strobes.
- `CS`, `R_NW`  out  1 each  memory select; R_NW = 1 read, 0 write.
- `ALU_ACC`, `ALU_add`, `ALU_sub`  out  1 each  ALU result to ACC; ALU operation select.
- `halted`  out  1  sticky illegal-opcode indicator.

## Operation
- Opcodes: LOAD=000, STORE=001, ADD=010, SUB=011, BNE=100. Opcodes 101–111 are illegal.
- States: FETCH_A, FETCH_D, DECODE, EXEC_RD, EXEC_WR, HALT. The encoding is free and must be a single state register.
- All outputs are combinational from state, `op`, `z_flag` and `mem_ready`. Any signal not listed for a state is 0.
- **FETCH_A:** PC_bus, load_MAR, INC_PC. Next state is FETCH_D.
- **FETCH_D:** CS=1, R_NW=1 throughout. When mem_ready=1: MDR_bus, load_IR, next DECODE. Otherwise hold with load_IR=0.
- **DECODE:**
  - op ∈ {LOAD, ADD, SUB}: Addr_bus, load_MAR; next EXEC_RD.
  - STORE: Addr_bus, load_MAR; next EXEC_WR.
  - BNE with z_flag=0: Addr_bus, load_PC; next FETCH_A.
  - BNE with z_flag=1: no strobes; next FETCH_A.
  - Illegal opcode: next HALT.
- **EXEC_RD:** CS=1, R_NW=1 throughout. When mem_ready=1: MDR_bus and load_ACC are asserted, plus:
  - LOAD: nothing further.
  - ADD: ALU_ACC, ALU_add.
  - SUB: ALU_ACC, ALU_sub.
  - Then next FETCH_A. Otherwise hold.
- **EXEC_WR:** CS=1, R_NW=0, ACC_bus, load_MDR throughout. Next FETCH_A when mem_ready=1, otherwise hold.
- **HALT:** all strobes 0, R_NW=1, halted=1. Stays in HALT until reset.
- R_NW defaults to 1 in every state except EXEC_WR.
- At most one bus driver (ACC_bus, PC_bus, Addr_bus, MDR_bus) may be high in any cycle. The bench asserts this every cycle.

## Timing
- Reset asserted: state = FETCH_A immediately (asynchronous). Outputs are PC_bus=1, load_MAR=1, INC_PC=1, R_NW=1, all others 0, halted=0.
- First state advance occurs on the first rising `clock` after reset deasserts.
- With mem_ready tied high:
  - LOAD/ADD/SUB/STORE take 4 cycles.
  - BNE takes 3 cycles.
- Each cycle of mem_ready=0 in FETCH_D, EXEC_RD or EXEC_WR adds exactly one cycle. Strobes are held stable while waiting.
- mem_ready is sampled only in the three memory states and ignored elsewhere.
- Reset mid-access (any state, including a wait or HALT) aborts it. The FSM is in FETCH_A in the same cycle and halted clears.
- op and z_flag are sampled in DECODE and EXEC_RD only. Changes at other times have no effect.

## Test plan
- **Reset:** assert reset mid-cycle in EXEC_WR → outputs immediately equal the FETCH_A values, halted=0, with no clock edge needed.
- **LOAD, mem_ready=1:** op=000 → 4 cycles. load_IR pulses in cycle 2; load_ACC=1, MDR_bus=1, ALU_ACC=0 in cycle 4; FETCH_A strobes in cycle 5.
- **ADD/SUB:** op=010 then op=011 → in EXEC_RD, ALU_add=1 (respectively ALU_sub=1) together with ALU_ACC=1 and load_ACC=1.
- **STORE with wait:** op=001, mem_ready low for 3 cycles in EXEC_WR → R_NW=0, CS=1, ACC_bus=1 held for 4 cycles. Next state is FETCH_A; instruction takes 7 cycles.
- **BNE:** op=100 with z_flag=0 → Addr_bus=1, load_PC=1 in DECODE, 3-cycle instruction. With z_flag=1 → no strobes in DECODE, next FETCH_A.
- **Illegal opcode:** op=111 → HALT after DECODE; halted=1 and all strobes 0 for 20 cycles, including with mem_ready toggling. Reset → FETCH_A.
